// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, colour constants and pattern presets for the LED arbiter
package led_pkg;

    localparam logic [2:0] COLOR_OFF   = 3'b000;
    localparam logic [2:0] COLOR_RED   = 3'b100;
    localparam logic [2:0] COLOR_GREEN = 3'b010;
    localparam logic [2:0] COLOR_BLUE  = 3'b001;
    localparam logic [2:0] COLOR_AMBER = 3'b110;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_SWITCH_ENC  = 2'd1;
    localparam logic [1:0] ST_GRANT_ENC   = 2'd2;
    localparam logic [1:0] ST_RELEASE_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_SWITCH  = ST_SWITCH_ENC,
        ST_GRANT   = ST_GRANT_ENC,
        ST_RELEASE = ST_RELEASE_ENC
    } state_t;

    typedef struct packed {
        logic [3:0][11:0] dur;
        logic [3:0][2:0]  col;
    } led_pat_t;

    function automatic led_pat_t mk_pat(
        input logic [11:0] d0, input logic [11:0] d1,
        input logic [11:0] d2, input logic [11:0] d3,
        input logic [2:0]  c0, input logic [2:0]  c1,
        input logic [2:0]  c2, input logic [2:0]  c3
    );
        led_pat_t p;
        p.dur[0] = d0;
        p.dur[1] = d1;
        p.dur[2] = d2;
        p.dur[3] = d3;
        p.col[0] = c0;
        p.col[1] = c1;
        p.col[2] = c2;
        p.col[3] = c3;
        return p;
    endfunction

    // Index order matches the 3-bit pattern code driven by each status source.
    localparam led_pat_t PATTERN_TABLE [8] = '{
        mk_pat(12'd0,   12'd0,   12'd0,   12'd0,   COLOR_OFF,   COLOR_OFF,   COLOR_OFF,  COLOR_OFF),
        mk_pat(12'd0,   12'd0,   12'd0,   12'd0,   COLOR_RED,   COLOR_OFF,   COLOR_OFF,  COLOR_OFF),
        mk_pat(12'd0,   12'd0,   12'd0,   12'd0,   COLOR_GREEN, COLOR_OFF,   COLOR_OFF,  COLOR_OFF),
        mk_pat(12'd0,   12'd0,   12'd0,   12'd0,   COLOR_BLUE,  COLOR_OFF,   COLOR_OFF,  COLOR_OFF),
        mk_pat(12'd500, 12'd500, 12'd0,   12'd0,   COLOR_RED,   COLOR_OFF,   COLOR_OFF,  COLOR_OFF),
        mk_pat(12'd250, 12'd250, 12'd0,   12'd0,   COLOR_AMBER, COLOR_OFF,   COLOR_OFF,  COLOR_OFF),
        mk_pat(12'd100, 12'd100, 12'd100, 12'd700, COLOR_RED,   COLOR_OFF,   COLOR_RED,  COLOR_OFF),
        mk_pat(12'd333, 12'd333, 12'd333, 12'd0,   COLOR_RED,   COLOR_GREEN, COLOR_BLUE, COLOR_OFF)
    };

endpackage

// File: rtl/led_pattern_arbiter_if.sv
// rtl/led_pattern_arbiter_if.sv - request/grant bundle between status sources and the LED arbiter
interface led_pattern_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [3*NUM_REQ-1:0] req_pat;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;

    modport master (output req, output req_pat, input grant, input busy);
    modport slave  (input req, input req_pat, output grant, output busy);
endinterface

// File: rtl/led_tick_1ms.sv
// rtl/led_tick_1ms.sv - free-running one-clock-wide millisecond strobe
module led_tick_1ms #(
    parameter int TERMINAL_CNT_1MS = 11999
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (TERMINAL_CNT_1MS > 0) ? $clog2(TERMINAL_CNT_1MS + 1) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TERMINAL_CNT_1MS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == TERM);
        cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_arbiter.sv
// rtl/led_pattern_arbiter.sv - fixed-priority owner selection for the shared RGB LED sequencer
module led_pattern_arbiter #(
    parameter int          NUM_REQ          = 4,
    parameter int          TERMINAL_CNT_1MS = 11999,
    parameter logic [11:0] MIN_HOLD_MS      = 12'd100
) (
    input  logic                 clk,
    input  logic                 rst,
    led_pattern_arbiter_if.slave bus,
    output logic [11:0]          duration0,
    output logic [11:0]          duration1,
    output logic [11:0]          duration2,
    output logic [11:0]          duration3,
    output logic [2:0]           color0,
    output logic [2:0]           color1,
    output logic [2:0]           color2,
    output logic [2:0]           color3
);
    import led_pkg::*;

    localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [2:0]         pat_q, pat_d;
    logic [11:0]        hold_q, hold_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [3:0][11:0]   dur_q, dur_d;
    logic [3:0][2:0]    col_q, col_d;

    logic               tick;
    logic               any_req;
    logic [WIN_W-1:0]   first_idx;
    logic [2:0]         first_pat;
    logic               owner_req;
    logic [2:0]         owner_pat;

    led_tick_1ms #(.TERMINAL_CNT_1MS(TERMINAL_CNT_1MS)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Scanning downward leaves the lowest set index, i.e. the highest priority.
    always_comb begin
        any_req   = |bus.req;
        first_idx = '0;
        first_pat = '0;
        owner_req = 1'b0;
        owner_pat = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                first_idx = WIN_W'(i);
                first_pat = bus.req_pat[3*i +: 3];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_q == WIN_W'(i)) begin
                owner_req = bus.req[i];
                owner_pat = bus.req_pat[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        pat_d   = pat_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        dur_d   = dur_q;
        col_d   = col_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    win_d   = first_idx;
                    pat_d   = first_pat;
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                dur_d   = PATTERN_TABLE[pat_q].dur;
                col_d   = PATTERN_TABLE[pat_q].col;
                grant_d = NUM_REQ'(1) << win_q;
                busy_d  = 1'b1;
                hold_d  = MIN_HOLD_MS;
                state_d = ST_GRANT;
            end
            ST_GRANT: begin
                // Request lines are ignored entirely until the hold time has run out.
                if (hold_q != 12'd0) begin
                    if (tick) begin
                        hold_d = hold_q - 12'd1;
                    end
                end else if (any_req && (first_idx < win_q || !owner_req)) begin
                    win_d   = first_idx;
                    pat_d   = first_pat;
                    state_d = ST_SWITCH;
                end else if (!owner_req) begin
                    state_d = ST_RELEASE;
                end else if (owner_pat != pat_q) begin
                    pat_d   = owner_pat;
                    state_d = ST_SWITCH;
                end
            end
            ST_RELEASE: begin
                dur_d   = '0;
                col_d   = '0;
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            pat_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            dur_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            pat_q   <= pat_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            dur_q   <= dur_d;
            col_q   <= col_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign duration0 = dur_q[0];
    assign duration1 = dur_q[1];
    assign duration2 = dur_q[2];
    assign duration3 = dur_q[3];
    assign color0    = col_q[0];
    assign color1    = col_q[1];
    assign color2    = col_q[2];
    assign color3    = col_q[3];

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// tb/tb_led_pattern_arbiter.sv - directed self-checking bench for led_pattern_arbiter
module tb_led_pattern_arbiter;

    localparam int          NUM_REQ = 4;
    localparam int          TERM    = 9;
    localparam logic [11:0] HOLD    = 12'd3;
    localparam int          PERIOD  = TERM + 1;

    logic clk = 1'b0;
    logic rst;
    logic [11:0] duration0, duration1, duration2, duration3;
    logic [2:0]  color0, color1, color2, color3;

    led_pattern_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    led_pattern_arbiter #(
        .NUM_REQ          (NUM_REQ),
        .TERMINAL_CNT_1MS (TERM),
        .MIN_HOLD_MS      (HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .duration0 (duration0),
        .duration1 (duration1),
        .duration2 (duration2),
        .duration3 (duration3),
        .color0    (color0),
        .color1    (color1),
        .color2    (color2),
        .color3    (color3)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wire [47:0] dur_all = {duration3, duration2, duration1, duration0};
    wire [11:0] col_all = {color3, color2, color1, color0};

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic set_pat(input int idx, input logic [2:0] p);
        bus.req_pat[3*idx +: 3] = p;
    endtask

    // Ticks reach the FSM at edges PERIOD+1, 2*PERIOD+1, ... counted from reset release.
    task automatic wait_ticks(input int n, input logic [3:0] exp_grant, input string tag);
        int seen = 0;
        while (seen < n) begin
            step(1);
            if (cyc >= PERIOD + 1 && (cyc - 1) % PERIOD == 0) seen++;
            n_checks++;
            if (bus.grant !== exp_grant || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_hold: cyc=%0d grant=%b busy=%b expected grant=%b busy=1",
                         tag, cyc, bus.grant, bus.busy, exp_grant);
            end
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || dur_all !== 48'h0 || col_all !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%b busy=%b dur=%h col=%h expected all zero",
                     bus.grant, bus.busy, dur_all, col_all);
        end
    endtask

    task automatic test_first_grant;
        bus.req = 4'b0100;
        set_pat(2, 3'd4);
        step(1);
        n_checks++;
        if (bus.grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL first_grant_latency: grant=%b expected 0000", bus.grant);
        end
        step(1);
        n_checks++;
        if (bus.grant !== 4'b0100 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant: grant=%b busy=%b expected 0100 busy=1", bus.grant, bus.busy);
        end
        n_checks++;
        if (dur_all !== 48'h000_000_1F4_1F4 || col_all !== 12'h004) begin
            n_fail++;
            $display("FAIL first_grant_pattern: dur=%h col=%h expected 0000001f41f4 004", dur_all, col_all);
        end
    endtask

    task automatic test_preempt_after_hold;
        wait_ticks(1, 4'b0100, "preempt_pre");
        bus.req = 4'b0101;
        set_pat(0, 3'd1);
        wait_ticks(2, 4'b0100, "preempt");
        step(1);
        n_checks++;
        if (bus.grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL preempt_eval: grant=%b expected 0100", bus.grant);
        end
        step(1);
        n_checks++;
        if (bus.grant !== 4'b0001 || bus.busy !== 1'b1 || dur_all !== 48'h0 || col_all !== 12'h004) begin
            n_fail++;
            $display("FAIL preempt_switch: grant=%b busy=%b dur=%h col=%h expected 0001 1 0 004",
                     bus.grant, bus.busy, dur_all, col_all);
        end
    endtask

    task automatic test_release;
        bus.req = 4'b0000;
        wait_ticks(3, 4'b0001, "release");
        step(1);
        n_checks++;
        if (bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL release_eval: grant=%b busy=%b expected 0001 1", bus.grant, bus.busy);
        end
        step(1);
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || dur_all !== 48'h0 || col_all !== 12'h0) begin
            n_fail++;
            $display("FAIL release_clear: grant=%b busy=%b dur=%h col=%h expected all zero",
                     bus.grant, bus.busy, dur_all, col_all);
        end
        step(1);
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release_idle: grant=%b busy=%b expected 0000 0", bus.grant, bus.busy);
        end
    endtask

    task automatic test_simultaneous_req;
        bus.req = 4'b1010;
        set_pat(1, 3'd4);
        set_pat(3, 3'd2);
        step(2);
        n_checks++;
        if (bus.grant !== 4'b0010 || dur_all !== 48'h000_000_1F4_1F4 || col_all !== 12'h004) begin
            n_fail++;
            $display("FAIL simultaneous: grant=%b dur=%h col=%h expected 0010 0000001f41f4 004",
                     bus.grant, dur_all, col_all);
        end
    endtask

    task automatic test_pattern_change;
        wait_ticks(3, 4'b0010, "patchg");
        step(2);
        n_checks++;
        if (bus.grant !== 4'b0010 || dur_all !== 48'h000_000_1F4_1F4) begin
            n_fail++;
            $display("FAIL patchg_steady: grant=%b dur=%h expected 0010 0000001f41f4", bus.grant, dur_all);
        end
        set_pat(1, 3'd7);
        step(1);
        n_checks++;
        if (dur_all !== 48'h000_000_1F4_1F4) begin
            n_fail++;
            $display("FAIL patchg_eval: dur=%h expected 0000001f41f4", dur_all);
        end
        step(1);
        n_checks++;
        if (bus.grant !== 4'b0010 || bus.busy !== 1'b1 || dur_all !== 48'h000_14D_14D_14D || col_all !== 12'h054) begin
            n_fail++;
            $display("FAIL patchg_switch: grant=%b busy=%b dur=%h col=%h expected 0010 1 00014d14d14d 054",
                     bus.grant, bus.busy, dur_all, col_all);
        end
    endtask

    task automatic test_back_to_back;
        wait_ticks(3, 4'b0010, "b2b");
        bus.req = 4'b1001;
        set_pat(0, 3'd6);
        step(2);
        n_checks++;
        if (bus.grant !== 4'b0001 || dur_all !== 48'h2BC_064_064_064 || col_all !== 12'h104) begin
            n_fail++;
            $display("FAIL drop_plus_higher: grant=%b dur=%h col=%h expected 0001 2bc064064064 104",
                     bus.grant, dur_all, col_all);
        end
        wait_ticks(3, 4'b0001, "handover");
        bus.req = 4'b1000;
        set_pat(3, 3'd3);
        step(2);
        n_checks++;
        if (bus.grant !== 4'b1000 || bus.busy !== 1'b1 || dur_all !== 48'h0 || col_all !== 12'h001) begin
            n_fail++;
            $display("FAIL handover_lower: grant=%b busy=%b dur=%h col=%h expected 1000 1 0 001",
                     bus.grant, bus.busy, dur_all, col_all);
        end
    endtask

    task automatic test_reset_mid_run;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || dur_all !== 48'h0 || col_all !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_mid_run: grant=%b busy=%b dur=%h col=%h expected all zero",
                     bus.grant, bus.busy, dur_all, col_all);
        end
        step(1);
        rst = 1'b0;
        cyc = 0;
        step(1);
        n_checks++;
        if (bus.grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL rearb_latency: grant=%b expected 0000", bus.grant);
        end
        step(1);
        n_checks++;
        if (bus.grant !== 4'b1000 || col_all !== 12'h001) begin
            n_fail++;
            $display("FAIL rearb_grant: grant=%b col=%h expected 1000 001", bus.grant, col_all);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.req_pat = '0;
        #12;
        test_reset;
        rst = 1'b0;
        cyc = 0;
        test_first_grant;
        test_preempt_after_hold;
        test_release;
        test_simultaneous_req;
        test_pattern_change;
        test_back_to_back;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
